// File: rtl/vend_pkg.sv
// vend_pkg: coin values, payout state encoding and coin-select enum shared by
// the vending FSM and the change payout controller.
package vend_pkg;

   localparam int NICKEL_C = 5;
   localparam int DIME_C   = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PULSE,
      ST_GAP,
      ST_FINISH
   } payout_state_e;

   typedef enum logic [1:0] {
      COIN_NONE,
      COIN_NICKEL,
      COIN_DIME
   } coin_sel_e;

   function automatic int coin_value(coin_sel_e coin);
      case (coin)
         COIN_NICKEL: return NICKEL_C;
         COIN_DIME:   return DIME_C;
         default:     return 0;
      endcase
   endfunction

endpackage

// File: rtl/payout_timer.sv
// payout_timer: loadable down-counter timing the eject pulse and settle gap.
// expired is high whenever the count has reached zero.
module payout_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/change_payout_ctrl.sv
// change_payout_ctrl: pays a change request as timed dime/nickel eject pulses and
// tracks tube inventory. Optional PAYOUT_AUDIT_EN adds the paid_total cents counter.
module change_payout_ctrl
   import vend_pkg::*;
#(
   parameter int AMT_W       = 5,
   parameter int INV_W       = 8,
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 8,
   parameter int NICKEL_INIT = 20,
   parameter int DIME_INIT   = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AMT_W-1:0] req_amount,
   output logic             eject_nickel,
   output logic             eject_dime,
   output logic             busy,
   output logic             done,
   output logic             short_err,
   output logic [AMT_W-1:0] short_amt,
   input  logic             refill_nickel,
   input  logic             refill_dime,
   output logic [INV_W-1:0] nickel_cnt,
   output logic [INV_W-1:0] dime_cnt
`ifdef PAYOUT_AUDIT_EN
   ,
   output logic [15:0]      paid_total
`endif
);

   localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
   localparam logic [AMT_W-1:0] NICKEL_A = AMT_W'(NICKEL_C);
   localparam logic [AMT_W-1:0] DIME_A   = AMT_W'(DIME_C);
   localparam logic [INV_W-1:0] INV_MAX  = '1;

   payout_state_e    state, next_state;
   coin_sel_e        sel;
   logic [AMT_W-1:0] rem;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expired;
   logic             nickel_take, dime_take;

   payout_timer #(.CNT_W(TMR_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   // NOTE: every signal this block writes gets a default first, so no path infers a latch.
   always_comb begin
      next_state = state;
      sel        = COIN_NONE;
      tmr_load   = 1'b0;
      tmr_val    = PULSE_LD;
      case (state)
         ST_IDLE: begin
            if (req_valid) next_state = ST_SELECT;
         end
         ST_SELECT: begin
            // Dime first; an empty dime tube falls through to nickels.
            if (rem >= DIME_A && dime_cnt != '0) begin
               sel = COIN_DIME;
            end else if (rem >= NICKEL_A && nickel_cnt != '0) begin
               sel = COIN_NICKEL;
            end
            if (sel != COIN_NONE) begin
               next_state = ST_PULSE;
               tmr_load   = 1'b1;
            end else begin
               next_state = ST_FINISH;
            end
         end
         ST_PULSE: begin
            if (tmr_expired) begin
               next_state = ST_GAP;
               tmr_load   = 1'b1;
               tmr_val    = GAP_LD;
            end
         end
         ST_GAP: begin
            if (tmr_expired) next_state = ST_SELECT;
         end
         ST_FINISH: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign nickel_take = (sel == COIN_NICKEL);
   assign dime_take   = (sel == COIN_DIME);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         rem          <= '0;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         short_err    <= 1'b0;
         short_amt    <= '0;
         eject_nickel <= 1'b0;
         eject_dime   <= 1'b0;
      end else begin
         state     <= next_state;
         req_ready <= (next_state == ST_IDLE);
         busy      <= (next_state != ST_IDLE);
         done      <= (next_state == ST_FINISH);

         // An eject line rises on PULSE entry and holds until PULSE is left.
         eject_dime   <= dime_take   || (eject_dime   && next_state == ST_PULSE);
         eject_nickel <= nickel_take || (eject_nickel && next_state == ST_PULSE);

         if (state == ST_IDLE && req_valid) begin
            rem <= req_amount;
         end else if (dime_take) begin
            rem <= rem - DIME_A;
         end else if (nickel_take) begin
            rem <= rem - NICKEL_A;
         end

         if (next_state == ST_FINISH) begin
            short_amt <= rem;
            short_err <= (rem != '0);
         end else begin
            short_err <= 1'b0;
         end
      end
   end

   // A refill coinciding with a payout on the same tube nets to zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nickel_cnt <= INV_W'(NICKEL_INIT);
         dime_cnt   <= INV_W'(DIME_INIT);
      end else begin
         if (nickel_take && !refill_nickel) begin
            nickel_cnt <= nickel_cnt - 1'b1;
         end else if (refill_nickel && !nickel_take && nickel_cnt != INV_MAX) begin
            nickel_cnt <= nickel_cnt + 1'b1;
         end
         if (dime_take && !refill_dime) begin
            dime_cnt <= dime_cnt - 1'b1;
         end else if (refill_dime && !dime_take && dime_cnt != INV_MAX) begin
            dime_cnt <= dime_cnt + 1'b1;
         end
      end
   end

`ifdef PAYOUT_AUDIT_EN
   logic [16:0] paid_sum;

   assign paid_sum = {1'b0, paid_total} + 17'(coin_value(sel));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         paid_total <= '0;
      end else if (sel != COIN_NONE) begin
         paid_total <= paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
      end
   end
`endif

endmodule
